// File: rtl/ms_uart_tx_arb.sv
// Two-requester round-robin arbiter that feeds single bytes into a UART TX FIFO.
// The owner keeps the link until its last byte or MAX_BURST bytes; each write is followed by one GAP cycle.
module ms_uart_tx_arb #(
  parameter int unsigned FULL_BIT  = 0,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  input  logic [7:0] UFR,
  output logic [7:0] TX_DIN,
  output logic       write_fifo,
  output logic [1:0] grant,
  output logic       busy,
  output logic [1:0] dbg_state_o
);

  // Handshake: a byte moves on a posedge where reqN_valid and reqN_ready are both high.
  // ready is combinational from valid and the UART full flag, and is only ever high for the owner in LOCK.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOCK = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  state_e     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       ptr_q, ptr_d;
  logic [7:0] burst_q, burst_d;
  logic [7:0] tx_din_q, tx_din_d;
  logic       wr_q, wr_d;
  logic       last_q, last_d;

  logic       uart_full;
  logic       own_valid;
  logic [7:0] own_data;
  logic       own_last;
  logic       accept;
  logic       unused_ufr;

  assign uart_full  = UFR[FULL_BIT];
  assign unused_ufr = ^UFR;

  always_comb begin
    own_valid = grant_q[1] ? req1_valid : req0_valid;
    own_data  = grant_q[1] ? req1_data  : req0_data;
    own_last  = grant_q[1] ? req1_last  : req0_last;
    accept    = (state_q == S_LOCK) && own_valid && !uart_full;
  end

  assign req0_ready  = accept && grant_q[0];
  assign req1_ready  = accept && grant_q[1];
  assign TX_DIN      = tx_din_q;
  assign write_fifo  = wr_q;
  assign grant       = grant_q;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    burst_d  = burst_q;
    tx_din_d = tx_din_q;
    wr_d     = 1'b0;
    last_d   = last_q;
    case (state_q)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          // ptr_q=0 favours requester 0 when both ask in the same cycle
          if (req0_valid && req1_valid) grant_d = ptr_q ? 2'b10 : 2'b01;
          else                          grant_d = req1_valid ? 2'b10 : 2'b01;
          burst_d = 8'd0;
          state_d = S_LOCK;
        end
      end
      S_LOCK: begin
        if (accept) begin
          tx_din_d = own_data;
          wr_d     = 1'b1;
          last_d   = own_last;
          burst_d  = burst_q + 8'd1;
          state_d  = S_GAP;
        end
      end
      S_GAP: begin
        if (last_q || (burst_q == BURST_MAX)) begin
          state_d = S_IDLE;
          grant_d = 2'b00;
          ptr_d   = grant_q[0];
        end else begin
          state_d = S_LOCK;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q  <= S_IDLE;
      grant_q  <= 2'b00;
      ptr_q    <= 1'b0;
      burst_q  <= 8'd0;
      tx_din_q <= 8'h00;
      wr_q     <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      burst_q  <= burst_d;
      tx_din_q <= tx_din_d;
      wr_q     <= wr_d;
      last_q   <= last_d;
    end
  end

endmodule
